// File: rtl/pfb_pkg.sv
// Shared PFB constants and helpers used by the multiplier wrapper, the tap
// accumulator and the decimated-sample FIFO.
package pfb_pkg;

    localparam int unsigned PFB_PROD_WIDTH = 26;
    localparam int unsigned PFB_TAPS       = 8;
    localparam int unsigned PFB_SHIFT      = 10;
    localparam int unsigned PFB_OUT_WIDTH  = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned      r;
        longint unsigned  p;
        r = 0;
        p = 64'd1;
        while (p < 64'(value)) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

    // Half-up rounding bias added before the right shift.
    function automatic longint unsigned pfb_round_bias(input int unsigned shift);
        return 64'd1 << (shift - 1);
    endfunction

    function automatic longint unsigned pfb_sat_value(input int unsigned out_width);
        return (64'd1 << out_width) - 64'd1;
    endfunction

endpackage

// File: rtl/pfb_round_sat.sv
// Combinational round-half-up, right shift and unsigned clamp of a branch sum.
module pfb_round_sat
    import pfb_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = PFB_PROD_WIDTH + 3,
    parameter int unsigned SHIFT     = PFB_SHIFT,
    parameter int unsigned OUT_WIDTH = PFB_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic [OUT_WIDTH-1:0] res_out
);

    localparam longint unsigned BIAS64 = pfb_round_bias(SHIFT);
    localparam longint unsigned SAT64  = pfb_sat_value(OUT_WIDTH);
    localparam logic [ACC_WIDTH:0] BIAS = BIAS64[ACC_WIDTH:0];
    localparam logic [ACC_WIDTH:0] SAT  = SAT64[ACC_WIDTH:0];

    logic [ACC_WIDTH:0] full;
    logic [ACC_WIDTH:0] shifted;

    // One extra bit keeps the biased sum from wrapping.
    always_comb begin
        full    = {1'b0, acc_in} + BIAS;
        shifted = full >> SHIFT;
        if (shifted > SAT) begin
            res_out = SAT[OUT_WIDTH-1:0];
        end else begin
            res_out = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pfb_tap_accumulator.sv
// Sums TAPS tap products per polyphase branch and emits the rounded, saturated
// result through a one-entry valid/ready output register.
module pfb_tap_accumulator
    import pfb_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PFB_PROD_WIDTH,
    parameter int unsigned TAPS       = PFB_TAPS,
    parameter int unsigned SHIFT      = PFB_SHIFT,
    parameter int unsigned OUT_WIDTH  = PFB_OUT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    input  logic                  prod_tlast,
    output logic                  prod_tready,
    output logic [OUT_WIDTH-1:0]  out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  err_frame
);

    localparam int unsigned CNT_W     = clog2(TAPS);
    localparam int unsigned ACC_WIDTH = PROD_WIDTH + CNT_W;

    logic [CNT_W-1:0]     tap_cnt_q, tap_cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_tdata_q, out_tdata_d;
    logic                 out_tvalid_q, out_tvalid_d;
    logic                 err_frame_q, err_frame_d;

    logic                 last_tap;
    logic                 final_pending;
    logic                 accept;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [OUT_WIDTH-1:0] round_res;

    pfb_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc_in  (acc_sum),
        .res_out (round_res)
    );

    always_comb begin
        last_tap      = (tap_cnt_q == CNT_W'(TAPS - 1));
        final_pending = last_tap || prod_tlast;
        // Only a beat that would overwrite a held output is stalled.
        prod_tready   = !out_tvalid_q || out_tready || !final_pending;
        accept        = prod_tvalid && prod_tready;
        if (tap_cnt_q == '0) begin
            acc_sum = {{CNT_W{1'b0}}, prod_tdata};
        end else begin
            acc_sum = acc_q + {{CNT_W{1'b0}}, prod_tdata};
        end

        tap_cnt_d    = tap_cnt_q;
        acc_d        = acc_q;
        out_tdata_d  = out_tdata_q;
        out_tvalid_d = out_tvalid_q;
        err_frame_d  = err_frame_q;

        if (out_tvalid_q && out_tready) begin
            out_tvalid_d = 1'b0;
        end

        if (accept) begin
            acc_d = acc_sum;
            if (final_pending) begin
                out_tdata_d  = round_res;
                out_tvalid_d = 1'b1;
                tap_cnt_d    = '0;
                if (last_tap != prod_tlast) begin
                    err_frame_d = 1'b1;
                end
            end else begin
                tap_cnt_d = tap_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tap_cnt_q    <= '0;
            acc_q        <= '0;
            out_tdata_q  <= '0;
            out_tvalid_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            tap_cnt_q    <= tap_cnt_d;
            acc_q        <= acc_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
    assign err_frame  = err_frame_q;

endmodule

// File: doc/pfb_tap_accumulator.md
# pfb_tap_accumulator

Consumes the unsigned tap products from the PFB coefficient multiplier, one product per accepted beat. Sums `TAPS` consecutive products into one polyphase branch output, then rounds, scales and saturates the sum. Emits the result through a one-entry registered output stage with valid/ready backpressure. It sits directly downstream of the multiplier and upstream of the decimated-sample FIFO feeding the FFT.

## Interface
- `PROD_WIDTH`, 26: product width. Input is unsigned; the MSB is the multiplier's zero-extension bit.
- `TAPS`, 8: products summed per output, ≥2.
- `SHIFT`, 10: right shift applied after rounding, ≥1.
- `OUT_WIDTH`, 16: unsigned output width.
- `ACC_WIDTH`: derived, `PROD_WIDTH + clog2(TAPS)`. Not overridable.

Ports:
- `ap_clk`  in  1  clock, rising edge
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `prod_tdata`  in  PROD_WIDTH  tap product
- `prod_tvalid`  in  1  product valid
- `prod_tlast`  in  1  upstream marks the final tap of a branch
- `prod_tready`  out  1  product accepted when `prod_tvalid && prod_tready`
- `out_tdata`  out  OUT_WIDTH  branch output
- `out_tvalid`  out  1  output valid
- `out_tready`  in  1  downstream ready
- `err_frame`  out  1  sticky `tlast`/count mismatch flag

## Operation
- `tap_cnt` counts 0..TAPS-1. The accumulator `acc` is ACC_WIDTH wide.
- On an accepted beat with `tap_cnt==0`: `acc <= prod`. On any other accepted beat: `acc <= acc + prod`.
- A beat is the final beat when `tap_cnt==TAPS-1` or `prod_tlast==1`.
- On the final beat:
  - Compute `full = acc_next + 2^(SHIFT-1)`, evaluated at ACC_WIDTH+1 bits so it cannot overflow.
  - Shift right by SHIFT.
  - If the result is ≥ 2^OUT_WIDTH, load `2^OUT_WIDTH-1`; otherwise load the result.
  - The value goes into `out_tdata`, `out_tvalid <= 1`, and `tap_cnt <= 0`.
- Mismatch: `prod_tlast` with `tap_cnt != TAPS-1`, or `tap_cnt==TAPS-1` without `prod_tlast`.
  - Sets `err_frame`. Only reset clears it.
  - The partial or unmarked sum is still emitted and the counter realigns to 0.
- Backpressure: `prod_tready = !out_tvalid || out_tready || !final_pending`, where `final_pending = (tap_cnt==TAPS-1) || prod_tlast`. Non-final beats are never stalled.
- `out_tvalid` clears on `out_tvalid && out_tready` unless a new final beat loads in the same cycle.

## Timing
- Reset (asynchronous, `ap_rst_n` low) forces:
  - `tap_cnt=0`, `acc=0`
  - `out_tvalid=0`, `out_tdata=0`
  - `err_frame=0`
- `prod_tready` is combinational. It is 1 whenever `out_tvalid=0`, including immediately after reset release.
- Latency: `out_tvalid` rises on the clock edge that accepts the final beat, so the output is visible the next cycle. Throughput is one product per cycle.
- Simultaneous drain and load: when `out_tready=1` and a final beat is accepted in the same cycle, the old word transfers, the new word loads, and `out_tvalid` stays 1 with no bubble.
- While `out_tvalid=1` and `out_tready=0`: `out_tdata` is stable and `prod_tready` drops only on a final-pending beat.
- Reset mid-branch discards the partial sum and any held output. No output is produced for that branch.
- `prod_tdata` and `prod_tlast` are ignored when `prod_tvalid=0` or `prod_tready=0`.

## Structure
- Shared package `pfb_pkg`:
  - `clog2` function
  - `pfb_round_sat` constants: rounding bias and saturation value as functions of SHIFT and OUT_WIDTH
  - default PROD_WIDTH/TAPS/OUT_WIDTH constants, also used by the multiplier wrapper and the FIFO
- One natural sub-module: `pfb_round_sat`, purely combinational. It takes ACC_WIDTH in and produces OUT_WIDTH out (round half-up, shift, clamp). The accumulator/counter/handshake logic stays in the top.

## Test plan
Bench configuration: TAPS=4, SHIFT=2, OUT_WIDTH=16, PROD_WIDTH=26.

- Products 1,2,3,4 back-to-back, `tlast` on the 4th, `out_tready=1` → `out_tdata=3` (10+2=12, >>2) one cycle after the 4th beat; `err_frame=0`.
- Four products of `0x3FFFFFF` → `out_tdata=0xFFFF` (saturated).
- Two branches back-to-back while `out_tready=0` → the first result holds. `prod_tready` drops only at the 4th beat of branch 2 and returns after one `out_tready` pulse; both outputs arrive in order.
- `tlast` on the 2nd product (values 5,6) → `out_tdata=3` ((11+2)>>2); `err_frame=1`. The next 4-tap branch is summed correctly from a zero count.
- Assert `ap_rst_n` after 3 taps with an output held → `out_tvalid=0`, `out_tdata=0`, `err_frame=0` immediately. A following 1,1,1,1 branch yields `out_tdata=1`.
- 1000 random products with random `prod_tvalid`/`out_tready` gaps → the scoreboard matches the reference sum/round/saturate model, with no lost or duplicated outputs.
